// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback stage and its load aligner.
package wb_pkg;
    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef enum logic [1:0] {
        LOAD_BYTE = 2'd0,
        LOAD_HALF = 2'd1,
        LOAD_WORD = 2'd2
    } load_size_e;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_e;
endpackage

// File: rtl/load_align.sv
// Combinational load-data lane select and sign/zero extension, plus the
// misaligned-access check for the given size/offset.
module load_align
    import wb_pkg::*;
(
    input  logic [XLEN-1:0] data_i,
    input  logic [1:0]      size_i,
    input  logic [1:0]      offset_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] value_o,
    output logic            misaligned_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    function automatic logic [XLEN-1:0] extend_byte(input logic [7:0] b, input logic uns);
        logic signed [7:0]      sb;
        logic signed [XLEN-1:0] sx;
        sb = b;
        sx = sb;
        return uns ? {{(XLEN-8){1'b0}}, b} : sx;
    endfunction

    function automatic logic [XLEN-1:0] extend_half(input logic [15:0] h, input logic uns);
        logic signed [15:0]     sh;
        logic signed [XLEN-1:0] sx;
        sh = h;
        sx = sh;
        return uns ? {{(XLEN-16){1'b0}}, h} : sx;
    endfunction

    always_comb begin
        case (offset_i)
            2'd0:    byte_lane = data_i[7:0];
            2'd1:    byte_lane = data_i[15:8];
            2'd2:    byte_lane = data_i[23:16];
            default: byte_lane = data_i[31:24];
        endcase
        half_lane = offset_i[1] ? data_i[31:16] : data_i[15:0];

        value_o      = data_i;
        misaligned_o = 1'b0;
        case (size_i)
            LOAD_BYTE: value_o = extend_byte(byte_lane, unsigned_i);
            LOAD_HALF: begin
                value_o      = extend_half(half_lane, unsigned_i);
                misaligned_o = offset_i[0];
            end
            // word and the reserved encoding behave identically
            default:   misaligned_o = (offset_i != 2'd0);
        endcase
    end
endmodule

// File: rtl/writeback.sv
// Writeback stage: accepts completed instructions, waits for load data,
// and issues one registered register-file write per accepted instruction.
module writeback
    import wb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    input  logic                 reg_write_i,
    input  logic [REG_IDX_W-1:0] reg_addr_i,
    input  logic [XLEN-1:0]      result_i,
    input  logic                 is_load_i,
    input  logic [1:0]           load_size_i,
    input  logic                 load_unsigned_i,
    input  logic [1:0]           load_offset_i,
    input  logic                 ldata_valid_i,
    input  logic [XLEN-1:0]      ldata_i,
    output logic                 write_o,
    output logic [REG_IDX_W-1:0] waddr_o,
    output logic [XLEN-1:0]      wdata_o,
    output logic                 pending_o,
    output logic [REG_IDX_W-1:0] pending_addr_o,
    output logic                 misaligned_o
);
    state_e               state_q, state_d;
    logic                 ready_p1, write_p1, pending_p1, misaligned_p1;
    logic [REG_IDX_W-1:0] waddr_p1, pending_addr_p1;
    logic [XLEN-1:0]      wdata_p1;

    logic [REG_IDX_W-1:0] ld_addr_p1;
    logic [1:0]           ld_size_p1, ld_offset_p1;
    logic                 ld_unsigned_p1, ld_wr_p1;

    logic                 accept, wr_en, accept_nl, accept_ld, load_done;
    logic [1:0]           al_size, al_offset;
    logic                 al_unsigned, al_misaligned;
    logic [XLEN-1:0]      al_value;

    // In IDLE the aligner checks the incoming request (data is don't-care);
    // in WAIT_LOAD it aligns the returning data with the latched fields.
    assign al_size     = (state_q == WAIT_LOAD) ? ld_size_p1     : load_size_i;
    assign al_offset   = (state_q == WAIT_LOAD) ? ld_offset_p1   : load_offset_i;
    assign al_unsigned = (state_q == WAIT_LOAD) ? ld_unsigned_p1 : load_unsigned_i;

    load_align u_load_align (
        .data_i       (ldata_i),
        .size_i       (al_size),
        .offset_i     (al_offset),
        .unsigned_i   (al_unsigned),
        .value_o      (al_value),
        .misaligned_o (al_misaligned)
    );

    assign accept    = input_valid_i & ready_p1;
    assign wr_en     = reg_write_i & (reg_addr_i != '0);
    assign accept_nl = accept & ~is_load_i;
    assign accept_ld = accept & is_load_i & ~al_misaligned;
    assign load_done = (state_q == WAIT_LOAD) & ldata_valid_i;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept_ld) state_d = WAIT_LOAD;
            WAIT_LOAD: if (ldata_valid_i) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Stage p0 -> p1: control and write-port registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= IDLE;
            ready_p1        <= 1'b1;
            write_p1        <= 1'b0;
            pending_p1      <= 1'b0;
            misaligned_p1   <= 1'b0;
            waddr_p1        <= '0;
            wdata_p1        <= '0;
            pending_addr_p1 <= '0;
        end else begin
            state_q       <= state_d;
            ready_p1      <= (state_d == IDLE);
            write_p1      <= (accept_nl & wr_en) | (load_done & ld_wr_p1);
            misaligned_p1 <= accept & is_load_i & al_misaligned;

            if (accept_nl & wr_en) begin
                waddr_p1 <= reg_addr_i;
                wdata_p1 <= result_i;
            end else if (load_done & ld_wr_p1) begin
                waddr_p1 <= ld_addr_p1;
                wdata_p1 <= al_value;
            end

            // Pending stays up through the write cycle of a load
            if (accept & wr_en & ~(is_load_i & al_misaligned)) begin
                pending_p1      <= 1'b1;
                pending_addr_p1 <= reg_addr_i;
            end else if (state_q != WAIT_LOAD) begin
                pending_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept_ld) begin
            ld_addr_p1     <= reg_addr_i;
            ld_size_p1     <= load_size_i;
            ld_offset_p1   <= load_offset_i;
            ld_unsigned_p1 <= load_unsigned_i;
            ld_wr_p1       <= wr_en;
        end
    end

    assign input_ready_o  = ready_p1;
    assign write_o        = write_p1;
    assign waddr_o        = waddr_p1;
    assign wdata_o        = wdata_p1;
    assign pending_o      = pending_p1;
    assign pending_addr_o = pending_addr_p1;
    assign misaligned_o   = misaligned_p1;
endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_writeback;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] result_i;
    logic        is_load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [1:0]  load_offset_i;
    logic        ldata_valid_i;
    logic [31:0] ldata_i;
    logic        write_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;
    logic        pending_o;
    logic [4:0]  pending_addr_o;
    logic        misaligned_o;

    int checks = 0;
    int errors = 0;

    writeback dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .input_valid_i   (input_valid_i),
        .input_ready_o   (input_ready_o),
        .reg_write_i     (reg_write_i),
        .reg_addr_i      (reg_addr_i),
        .result_i        (result_i),
        .is_load_i       (is_load_i),
        .load_size_i     (load_size_i),
        .load_unsigned_i (load_unsigned_i),
        .load_offset_i   (load_offset_i),
        .ldata_valid_i   (ldata_valid_i),
        .ldata_i         (ldata_i),
        .write_o         (write_o),
        .waddr_o         (waddr_o),
        .wdata_o         (wdata_o),
        .pending_o       (pending_o),
        .pending_addr_o  (pending_addr_o),
        .misaligned_o    (misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference: pick the addressed lane arithmetically, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] d, input int size,
                                             input int off, input bit uns);
        int unsigned v;
        if (size == 0) begin
            v = (d >> (8 * off)) & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (size == 1) begin
            v = (d >> (16 * (off / 2))) & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = d;
        end
        return v;
    endfunction

    function automatic bit ref_misaligned(input int size, input int off);
        if (size == 0) return 1'b0;
        if (size == 1) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic idle_inputs();
        input_valid_i   = 1'b0;
        reg_write_i     = 1'b0;
        reg_addr_i      = '0;
        result_i        = '0;
        is_load_i       = 1'b0;
        load_size_i     = '0;
        load_unsigned_i = 1'b0;
        load_offset_i   = '0;
        ldata_valid_i   = 1'b0;
        ldata_i         = '0;
    endtask

    task automatic present(input logic wr, input logic [4:0] addr, input logic [31:0] res,
                           input logic ld, input logic [1:0] sz, input logic uns,
                           input logic [1:0] off);
        input_valid_i   = 1'b1;
        reg_write_i     = wr;
        reg_addr_i      = addr;
        result_i        = res;
        is_load_i       = ld;
        load_size_i     = sz;
        load_unsigned_i = uns;
        load_offset_i   = off;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        checks++; if (input_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", input_ready_o); end
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write_o); end
        checks++; if (pending_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", pending_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", misaligned_o); end
        checks++; if (waddr_o !== 5'd0 || pending_addr_o !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d/%0d want 0/0", waddr_o, pending_addr_o); end
        checks++; if (wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_nonload();
        present(1'b1, 5'd5, 32'h1234_5678, 1'b0, 2'd2, 1'b0, 2'd0);
        @(negedge clk_i);
        idle_inputs();
        checks++; if (write_o !== 1'b1) begin errors++; $display("FAIL nl_write: got %b want 1", write_o); end
        checks++; if (waddr_o !== 5'd5) begin errors++; $display("FAIL nl_waddr: got %0d want 5", waddr_o); end
        checks++; if (wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL nl_wdata: got %h want 12345678", wdata_o); end
        checks++; if (pending_o !== 1'b1 || pending_addr_o !== 5'd5) begin errors++; $display("FAIL nl_pending: got %b/%0d want 1/5", pending_o, pending_addr_o); end
        @(negedge clk_i);
        checks++; if (write_o !== 1'b0 || pending_o !== 1'b0) begin errors++; $display("FAIL nl_after: got write %b pending %b want 0 0", write_o, pending_o); end
        checks++; if (waddr_o !== 5'd5 || wdata_o !== 32'h1234_5678) begin errors++; $display("FAIL nl_hold: got %0d/%h want 5/12345678", waddr_o, wdata_o); end
    endtask

    task automatic test_byte_load();
        present(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b1, 2'd0, 1'b0, 2'd3);
        @(negedge clk_i);
        idle_inputs();
        checks++; if (pending_o !== 1'b1 || pending_addr_o !== 5'd9) begin errors++; $display("FAIL lb_pending: got %b/%0d want 1/9", pending_o, pending_addr_o); end
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk_i);
            checks++; if (input_ready_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL lb_wait: got ready %b write %b want 0 0", input_ready_o, write_o); end
        end
        @(negedge clk_i);
        ldata_valid_i = 1'b1;
        ldata_i       = 32'h80AA_BBCC;
        @(negedge clk_i);
        idle_inputs();
        checks++; if (write_o !== 1'b1 || waddr_o !== 5'd9) begin errors++; $display("FAIL lb_write: got %b/%0d want 1/9", write_o, waddr_o); end
        checks++; if (wdata_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wdata: got %h want ffffff80", wdata_o); end
        checks++; if (pending_o !== 1'b1 || input_ready_o !== 1'b1) begin errors++; $display("FAIL lb_wcycle: got pending %b ready %b want 1 1", pending_o, input_ready_o); end
        @(negedge clk_i);
        checks++; if (write_o !== 1'b0 || pending_o !== 1'b0) begin errors++; $display("FAIL lb_after: got write %b pending %b want 0 0", write_o, pending_o); end
    endtask

    task automatic test_half_load();
        present(1'b1, 5'd3, 32'h0, 1'b1, 2'd1, 1'b1, 2'd2);
        @(negedge clk_i);
        idle_inputs();
        ldata_valid_i = 1'b1;
        ldata_i       = 32'h8001_0000;
        @(negedge clk_i);
        idle_inputs();
        checks++; if (write_o !== 1'b1 || waddr_o !== 5'd3) begin errors++; $display("FAIL lh_write: got %b/%0d want 1/3", write_o, waddr_o); end
        checks++; if (wdata_o !== 32'h0000_8001) begin errors++; $display("FAIL lh_wdata: got %h want 00008001", wdata_o); end
        @(negedge clk_i);
    endtask

    task automatic test_misaligned();
        present(1'b1, 5'd7, 32'h0, 1'b1, 2'd2, 1'b0, 2'd1);
        @(negedge clk_i);
        idle_inputs();
        checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b want 1", misaligned_o); end
        checks++; if (write_o !== 1'b0 || pending_o !== 1'b0 || input_ready_o !== 1'b1) begin errors++; $display("FAIL mis_side: got write %b pending %b ready %b want 0 0 1", write_o, pending_o, input_ready_o); end
        @(negedge clk_i);
        checks++; if (misaligned_o !== 1'b0 || write_o !== 1'b0) begin errors++; $display("FAIL mis_after: got mis %b write %b want 0 0", misaligned_o, write_o); end
    endtask

    task automatic test_no_write();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) present(1'b1, 5'd0, 32'hAAAA_0000 + i, 1'b0, 2'd2, 1'b0, 2'd0);
            else            present(1'b0, 5'd6 + 5'(i), 32'h5555_0000 + i, 1'b0, 2'd2, 1'b0, 2'd0);
            @(negedge clk_i);
            checks++; if (write_o !== 1'b0 || pending_o !== 1'b0 || input_ready_o !== 1'b1) begin errors++; $display("FAIL nowr_%0d: got write %b pending %b ready %b want 0 0 1", i, write_o, pending_o, input_ready_o); end
        end
        idle_inputs();
        @(negedge clk_i);
        checks++; if (write_o !== 1'b0) begin errors++; $display("FAIL nowr_tail: got %b want 0", write_o); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            present(1'b1, 5'd20 + 5'(i), 32'hC0DE_0000 + i, 1'b0, 2'd2, 1'b0, 2'd0);
            @(negedge clk_i);
            checks++; if (write_o !== 1'b1 || waddr_o !== 5'd20 + 5'(i) || wdata_o !== 32'hC0DE_0000 + i) begin errors++; $display("FAIL b2b_%0d: got %b/%0d/%h want 1/%0d/%h", i, write_o, waddr_o, wdata_o, 20 + i, 32'hC0DE_0000 + i); end
        end
        idle_inputs();
        @(negedge clk_i);
    endtask

    task automatic test_reset_midload();
        present(1'b1, 5'd12, 32'h0, 1'b1, 2'd2, 1'b0, 2'd0);
        @(negedge clk_i);
        idle_inputs();
        checks++; if (input_ready_o !== 1'b0 || pending_o !== 1'b1) begin errors++; $display("FAIL rml_wait: got ready %b pending %b want 0 1", input_ready_o, pending_o); end
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (input_ready_o !== 1'b1 || pending_o !== 1'b0) begin errors++; $display("FAIL rml_async: got ready %b pending %b want 1 0", input_ready_o, pending_o); end
        checks++; if (write_o !== 1'b0 || wdata_o !== 32'h0) begin errors++; $display("FAIL rml_outs: got write %b wdata %h want 0 0", write_o, wdata_o); end
        @(negedge clk_i);
        rst_ni        = 1'b1;
        ldata_valid_i = 1'b1;
        ldata_i       = 32'h1357_9BDF;
        @(negedge clk_i);
        idle_inputs();
        checks++; if (write_o !== 1'b0 || pending_o !== 1'b0 || input_ready_o !== 1'b1) begin errors++; $display("FAIL rml_ignored: got write %b pending %b ready %b want 0 0 1", write_o, pending_o, input_ready_o); end
        @(negedge clk_i);
    endtask

    task automatic test_random();
        bit          m_wait, m_wr, m_uns, acc;
        logic [4:0]  m_addr;
        logic [1:0]  m_size, m_off;
        logic        e_ready, e_write, e_pend, e_mis;
        logic [4:0]  e_waddr, e_paddr;
        logic [31:0] e_wdata;
        rst_ni = 1'b0;
        idle_inputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        m_wait = 0; m_wr = 0; m_uns = 0; m_addr = 0; m_size = 0; m_off = 0;
        e_ready = 1; e_write = 0; e_pend = 0; e_mis = 0; e_waddr = 0; e_paddr = 0; e_wdata = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            // drive this cycle's inputs and predict the next cycle's outputs
            input_valid_i   = ($urandom_range(0, 3) != 0);
            reg_write_i     = ($urandom_range(0, 4) != 0);
            reg_addr_i      = 5'($urandom_range(0, 31));
            result_i        = $urandom;
            is_load_i       = ($urandom_range(0, 1) != 0);
            load_size_i     = 2'($urandom_range(0, 3));
            load_unsigned_i = ($urandom_range(0, 1) != 0);
            load_offset_i   = 2'($urandom_range(0, 3));
            ldata_valid_i   = ($urandom_range(0, 2) == 0);
            ldata_i         = $urandom;

            acc     = input_valid_i && e_ready;
            e_write = 0;
            e_mis   = 0;
            if (m_wait) begin
                e_pend = m_wr;
                if (ldata_valid_i) begin
                    m_wait = 0;
                    if (m_wr) begin
                        e_write = 1;
                        e_waddr = m_addr;
                        e_wdata = ref_load(ldata_i, m_size, m_off, m_uns);
                    end
                end
            end else begin
                e_pend = 0;
                if (acc) begin
                    if (!is_load_i) begin
                        if (reg_write_i && reg_addr_i != 0) begin
                            e_write = 1; e_waddr = reg_addr_i; e_wdata = result_i;
                            e_pend = 1;  e_paddr = reg_addr_i;
                        end
                    end else if (ref_misaligned(load_size_i, load_offset_i)) begin
                        e_mis = 1;
                    end else begin
                        m_wait = 1; m_addr = reg_addr_i; m_size = load_size_i;
                        m_off = load_offset_i; m_uns = load_unsigned_i;
                        m_wr = reg_write_i && reg_addr_i != 0;
                        if (m_wr) begin e_pend = 1; e_paddr = reg_addr_i; end
                    end
                end
            end
            e_ready = !m_wait;

            @(negedge clk_i);
            checks++; if (input_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, input_ready_o, e_ready); end
            checks++; if (write_o !== e_write) begin errors++; $display("FAIL rnd_write c%0d: got %b want %b", cyc, write_o, e_write); end
            checks++; if (waddr_o !== e_waddr || wdata_o !== e_wdata) begin errors++; $display("FAIL rnd_wport c%0d: got %0d/%h want %0d/%h", cyc, waddr_o, wdata_o, e_waddr, e_wdata); end
            checks++; if (pending_o !== e_pend || pending_addr_o !== e_paddr) begin errors++; $display("FAIL rnd_pending c%0d: got %b/%0d want %b/%0d", cyc, pending_o, pending_addr_o, e_pend, e_paddr); end
            checks++; if (misaligned_o !== e_mis) begin errors++; $display("FAIL rnd_misaligned c%0d: got %b want %b", cyc, misaligned_o, e_mis); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_nonload();
        test_byte_load();
        test_half_load();
        test_misaligned();
        test_no_write();
        test_back_to_back();
        test_reset_midload();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
